// File: rtl/i2c_seq_defs.sv
// Shared definitions for the I2C command sequencer and I2C_Comm:
// command-table entry layout, transfer direction/length encodings, sequencer states.
package i2c_seq_defs;

  localparam int unsigned ENTRY_W = 25;
  localparam int unsigned IDX_W   = 8;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned ADDR_W  = 7;

  localparam logic RD_OP  = 1'b1;
  localparam logic WR_OP  = 1'b0;
  localparam logic NB_ONE = 1'b0;
  localparam logic NB_TWO = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_ISSUE       = 3'd1,
    ST_WAIT_ACCEPT = 3'd2,
    ST_WAIT_DONE   = 3'd3,
    ST_GAP         = 3'd4,
    ST_DONE        = 3'd5,
    ST_ERR         = 3'd6
  } seq_state_e;

  // Entry layout {rd_wr, num_bytes, addr, data}, MSB first.
  typedef struct packed {
    logic              rd_wr;
    logic              num_bytes;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } cmd_entry_t;

endpackage

// File: rtl/i2c_cmd_rom.sv
// Power-up command table for the ADC/clock parts; indices at or beyond NUM_CMDS read as zero.
module i2c_cmd_rom
  import i2c_seq_defs::*;
#(
  parameter int unsigned NUM_CMDS = 8
) (
  input  logic [IDX_W-1:0]   index,
  output logic [ENTRY_W-1:0] entry
);

  cmd_entry_t word_c;

  always_comb begin
    word_c = '0;
    if (32'(index) < NUM_CMDS) begin
      case (index)
        8'd0:    word_c = '{rd_wr: WR_OP, num_bytes: NB_TWO, addr: 7'h55, data: 16'hAAAA};
        8'd1:    word_c = '{rd_wr: WR_OP, num_bytes: NB_TWO, addr: 7'h2A, data: 16'h1234};
        8'd2:    word_c = '{rd_wr: RD_OP, num_bytes: NB_TWO, addr: 7'h48, data: 16'h0000};
        8'd3:    word_c = '{rd_wr: RD_OP, num_bytes: NB_ONE, addr: 7'h48, data: 16'h0000};
        8'd4:    word_c = '{rd_wr: WR_OP, num_bytes: NB_ONE, addr: 7'h10, data: 16'h00C3};
        8'd5:    word_c = '{rd_wr: WR_OP, num_bytes: NB_TWO, addr: 7'h3C, data: 16'h5A5A};
        8'd6:    word_c = '{rd_wr: RD_OP, num_bytes: NB_TWO, addr: 7'h21, data: 16'h0000};
        8'd7:    word_c = '{rd_wr: WR_OP, num_bytes: NB_ONE, addr: 7'h66, data: 16'h0001};
        default: word_c = '0;
      endcase
    end
  end

  assign entry = word_c;

endmodule

// File: rtl/i2c_cmd_sequencer.sv
// Walks the I2C command table, one I2C_Comm transaction per entry, and reports done/error.
// Optional busy watchdog enabled by defining TIMEOUT_EN.
module i2c_cmd_sequencer
  import i2c_seq_defs::*;
#(
  parameter int unsigned NUM_CMDS       = 8,
  parameter int unsigned GAP_CYCLES     = 16,
  parameter int unsigned ACCEPT_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 200000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              seq_busy,
  output logic              seq_done,
  output logic              seq_error,
  output logic [IDX_W-1:0]  cmd_index,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              i2c_load,
  output logic [ADDR_W-1:0] i2c_addr,
  output logic              i2c_numBytes,
  output logic              i2c_rd_wr,
  output logic [DATA_W-1:0] i2c_wr_data,
  output logic              i2c_data_oe,
  input  logic [DATA_W-1:0] i2c_rd_data,
  input  logic              i2c_busy,
  input  logic              i2c_dataReady
);

  localparam int unsigned CNT_MAX = (GAP_CYCLES > ACCEPT_CYCLES) ? GAP_CYCLES : ACCEPT_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] ACC_LAST = CNT_W'(ACCEPT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CNT_MAX);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CMDS - 1);

  seq_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    cmd_index_q, cmd_index_d;
  cmd_entry_t          entry_q, entry_d, entry_c;
  logic [ENTRY_W-1:0]  rom_word;
  logic                captured_q, captured_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic                rd_valid_q, rd_valid_d;
  logic                load_q, load_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                start_prev_q;
  logic                start_rise;
  logic                can_start;
  logic                timeout_hit;

  assign start_rise = start & ~start_prev_q;
  assign can_start  = (state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERR);

  i2c_cmd_rom #(.NUM_CMDS(NUM_CMDS)) u_rom (
    .index (cmd_index_d),
    .entry (rom_word)
  );
  assign entry_c = cmd_entry_t'(rom_word);

`ifdef TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wdog_q, wdog_d;

  // Busy watchdog: counts WAIT_DONE cycles, rearmed by every ISSUE.
  always_comb begin
    wdog_d = wdog_q;
    if (state_q == ST_ISSUE) begin
      wdog_d = '0;
    end else if (state_q == ST_WAIT_DONE && wdog_q != WD_W'(TIMEOUT_CYCLES)) begin
      wdog_d = wdog_q + 1'b1;
    end
  end

  assign timeout_hit = (state_q == ST_WAIT_DONE) && i2c_busy &&
                       (wdog_q == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wdog_q <= '0;
    else        wdog_q <= wdog_d;
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^32'(TIMEOUT_CYCLES);
  assign timeout_hit    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: if (start_rise) state_d = ST_ISSUE;
      ST_ISSUE:                 state_d = ST_WAIT_ACCEPT;
      ST_WAIT_ACCEPT:           if (i2c_busy || cnt_q >= ACC_LAST) state_d = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        if (timeout_hit)    state_d = ST_ERR;
        else if (!i2c_busy) state_d = ST_GAP;
      end
      ST_GAP: begin
        if (cnt_q >= GAP_LAST) state_d = (cmd_index_q == LAST_IDX) ? ST_DONE : ST_ISSUE;
      end
      default:                  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_d       = cnt_q;
    cmd_index_d = cmd_index_q;
    entry_d     = entry_q;
    captured_d  = captured_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;

    // Shared state timer: restarts on every transition, saturates otherwise.
    if (state_d != state_q)  cnt_d = '0;
    else if (cnt_q != CNT_SAT) cnt_d = cnt_q + 1'b1;

    if (can_start && start_rise)                       cmd_index_d = '0;
    else if (state_q == ST_GAP && state_d == ST_ISSUE) cmd_index_d = cmd_index_q + 8'd1;

    if (state_d == ST_ISSUE) begin
      entry_d    = entry_c;
      captured_d = 1'b0;
    end

    // Only the first dataReady of a read entry is captured.
    if (state_q == ST_WAIT_DONE && i2c_dataReady && !captured_q && entry_q.rd_wr == RD_OP) begin
      captured_d = 1'b1;
      rd_valid_d = 1'b1;
      rd_data_d  = (entry_q.num_bytes == NB_ONE) ? {8'h00, i2c_rd_data[7:0]} : i2c_rd_data;
    end

    load_d = (state_d == ST_ISSUE);
    busy_d = (state_d == ST_ISSUE) || (state_d == ST_WAIT_ACCEPT) ||
             (state_d == ST_WAIT_DONE) || (state_d == ST_GAP);
    done_d = (state_d == ST_DONE);
    err_d  = (state_d == ST_ERR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      cmd_index_q  <= '0;
      entry_q      <= '0;
      captured_q   <= 1'b0;
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
      load_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      start_prev_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      cmd_index_q  <= cmd_index_d;
      entry_q      <= entry_d;
      captured_q   <= captured_d;
      rd_data_q    <= rd_data_d;
      rd_valid_q   <= rd_valid_d;
      load_q       <= load_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      start_prev_q <= start;
    end
  end

  assign seq_busy     = busy_q;
  assign seq_done     = done_q;
  assign seq_error    = err_q;
  assign cmd_index    = cmd_index_q;
  assign rd_data      = rd_data_q;
  assign rd_valid     = rd_valid_q;
  assign i2c_load     = load_q;
  assign i2c_data_oe  = load_q;
  assign i2c_addr     = entry_q.addr;
  assign i2c_numBytes = entry_q.num_bytes;
  assign i2c_rd_wr    = entry_q.rd_wr;
  assign i2c_wr_data  = entry_q.data;

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Scoreboard bench for i2c_cmd_sequencer: randomized I2C_Comm responder, expected loads and
// read captures queued from the bench's own copy of the command table.
module tb_i2c_cmd_sequencer;

  localparam int NUM        = 8;
  localparam int GAP        = 16;
  localparam int TB_TIMEOUT = 300;

  localparam logic [24:0] TBL [8] = '{
    {1'b0, 1'b1, 7'h55, 16'hAAAA},
    {1'b0, 1'b1, 7'h2A, 16'h1234},
    {1'b1, 1'b1, 7'h48, 16'h0000},
    {1'b1, 1'b0, 7'h48, 16'h0000},
    {1'b0, 1'b0, 7'h10, 16'h00C3},
    {1'b0, 1'b1, 7'h3C, 16'h5A5A},
    {1'b1, 1'b1, 7'h21, 16'h0000},
    {1'b0, 1'b0, 7'h66, 16'h0001}
  };

  typedef struct {
    logic [24:0] e;
    int          idx;
  } exp_load_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        seq_busy, seq_done, seq_error, rd_valid;
  logic [7:0]  cmd_index;
  logic [15:0] rd_data, i2c_wr_data, i2c_rd_data;
  logic        i2c_load, i2c_numBytes, i2c_rd_wr, i2c_data_oe;
  logic [6:0]  i2c_addr;
  logic        i2c_busy, i2c_dataReady;

  exp_load_t   exp_load_q[$];
  logic [15:0] exp_rd_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_load = -1;
  int n_loads = 0;
  int slave_idx = 0;
  int stuck_idx = -1;
  bit stuck_release = 1'b0;
  bit prev_rd_valid = 1'b0;

  i2c_cmd_sequencer #(
    .NUM_CMDS(NUM), .GAP_CYCLES(GAP), .ACCEPT_CYCLES(4), .TIMEOUT_CYCLES(TB_TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .seq_busy(seq_busy), .seq_done(seq_done), .seq_error(seq_error),
    .cmd_index(cmd_index), .rd_data(rd_data), .rd_valid(rd_valid),
    .i2c_load(i2c_load), .i2c_addr(i2c_addr), .i2c_numBytes(i2c_numBytes),
    .i2c_rd_wr(i2c_rd_wr), .i2c_wr_data(i2c_wr_data), .i2c_data_oe(i2c_data_oe),
    .i2c_rd_data(i2c_rd_data), .i2c_busy(i2c_busy), .i2c_dataReady(i2c_dataReady)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_ge(input string name, input int act, input int min);
    checks++;
    if (act < min) begin
      errors++;
      $display("FAIL %s: got %0d expected at least %0d at t=%0t", name, act, min, $time);
    end
  endtask

  function automatic logic [63:0] all_outputs();
    return 64'({seq_busy, seq_done, seq_error, cmd_index, rd_data, rd_valid, i2c_load,
                i2c_addr, i2c_numBytes, i2c_rd_wr, i2c_wr_data, i2c_data_oe});
  endfunction

  // Monitor: pops the scoreboard whenever the DUT launches a load or presents read data.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("data_oe_eq_load", 64'(i2c_data_oe), 64'(i2c_load));
      if (i2c_load) begin
        if (exp_load_q.size() == 0) begin
          chk("unexpected_load", 64'(1), 64'(0));
        end else begin
          exp_load_t x;
          x = exp_load_q.pop_front();
          chk("load_rd_wr", 64'(i2c_rd_wr), 64'(x.e[24]));
          chk("load_numbytes", 64'(i2c_numBytes), 64'(x.e[23]));
          chk("load_addr", 64'(i2c_addr), 64'(x.e[22:16]));
          chk("load_wr_data", 64'(i2c_wr_data), 64'(x.e[15:0]));
          chk("load_cmd_index", 64'(cmd_index), 64'(x.idx));
          chk("load_seq_busy", 64'(seq_busy), 64'(1));
        end
        if (last_load >= 0) chk_ge("load_spacing", cyc - last_load, GAP + 2);
        last_load = cyc;
        n_loads++;
      end
      if (rd_valid) begin
        chk("rd_valid_single", 64'(prev_rd_valid), 64'(0));
        if (exp_rd_q.size() == 0) chk("unexpected_rd_valid", 64'(1), 64'(0));
        else                      chk("rd_data", 64'(rd_data), 64'(exp_rd_q.pop_front()));
      end
      prev_rd_valid = rd_valid;
    end
  end

  // I2C_Comm responder for one transaction; pushes the expected capture for reads.
  task automatic slave_txn();
    logic [24:0] e;
    logic [15:0] v1, v2;
    int d, h, k1, k2;
    e = (slave_idx < NUM) ? TBL[3'(slave_idx)] : 25'h0;
    if (slave_idx == stuck_idx) begin
      @(negedge clk);
      i2c_busy = 1'b1;
      for (int i = 0; i < 5000 && rst_n && !stuck_release; i++) @(negedge clk);
      i2c_busy = 1'b0;
      return;
    end
    if (slave_idx == 4 || (!e[24] && $urandom_range(0, 4) == 0)) return;
    d  = $urandom_range(1, 3);
    h  = $urandom_range(3, 50);
    k1 = $urandom_range(1, h - 1);
    k2 = (k1 + 2 <= h - 1 && $urandom_range(0, 2) == 0) ? $urandom_range(k1 + 2, h - 1) : -1;
    v1 = (slave_idx == 2 || slave_idx == 3) ? 16'hBEEF : 16'($urandom);
    v2 = 16'($urandom);
    repeat (d) @(negedge clk);
    if (!rst_n) return;
    i2c_busy = 1'b1;
    for (int i = 1; i <= h; i++) begin
      @(negedge clk);
      i2c_dataReady = 1'b0;
      if (!rst_n || i == h) break;
      if (i == k1) begin
        i2c_dataReady = 1'b1;
        i2c_rd_data   = v1;
        if (e[24]) exp_rd_q.push_back(e[23] ? v1 : {8'h00, v1[7:0]});
      end else if (i == k2) begin
        i2c_dataReady = 1'b1;
        i2c_rd_data   = v2;
      end
    end
    i2c_busy      = 1'b0;
    i2c_dataReady = 1'b0;
  endtask

  initial begin
    i2c_busy = 1'b0;
    i2c_dataReady = 1'b0;
    i2c_rd_data = 16'h0;
    forever begin
      @(negedge clk);
      if (rst_n && i2c_load) begin
        slave_txn();
        slave_idx++;
      end
    end
  end

  task automatic queue_entries(input int upto);
    for (int i = 0; i <= upto; i++) begin
      exp_load_t x;
      x.e   = TBL[3'(i)];
      x.idx = i;
      exp_load_q.push_back(x);
    end
  endtask

  task automatic pulse_start();
    slave_idx = 0;
    last_load = -1;
    n_loads   = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", 64'(seq_busy), 64'(1));
    chk("done_cleared", 64'(seq_done), 64'(0));
    chk("error_cleared", 64'(seq_error), 64'(0));
  endtask

  task automatic run_table(input bit spurious);
    queue_entries(NUM - 1);
    pulse_start();
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (seq_done) break;
      start = spurious && ($urandom_range(0, 40) == 0);
    end
    start = 1'b0;
    chk("seq_done", 64'(seq_done), 64'(1));
    chk("busy_at_done", 64'(seq_busy), 64'(0));
    chk("index_at_done", 64'(cmd_index), 64'(NUM - 1));
    chk("load_count", 64'(n_loads), 64'(NUM));
    chk("loads_pending", 64'(exp_load_q.size()), 64'(0));
    chk("reads_pending", 64'(exp_rd_q.size()), 64'(0));
  endtask

  task automatic reset_mid_run();
    int waited;
    queue_entries(NUM - 1);
    pulse_start();
    waited = 0;
    while (!i2c_busy && waited < 3000) begin
      @(negedge clk);
      waited++;
    end
    chk("busy_seen_before_reset", 64'(i2c_busy), 64'(1));
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_outputs", all_outputs(), 64'(0));
    repeat (3) @(negedge clk);
    exp_load_q.delete();
    exp_rd_q.delete();
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_after_reset", 64'(seq_busy), 64'(0));
  endtask

`ifdef TIMEOUT_EN
  task automatic timeout_run();
    int loads_at_err;
    stuck_idx = 3;
    stuck_release = 1'b0;
    queue_entries(3);
    pulse_start();
    for (int i = 0; i < TB_TIMEOUT + 3000; i++) begin
      @(negedge clk);
      if (seq_error) break;
    end
    chk("seq_error", 64'(seq_error), 64'(1));
    chk("busy_at_error", 64'(seq_busy), 64'(0));
    chk("index_at_error", 64'(cmd_index), 64'(3));
    chk("done_at_error", 64'(seq_done), 64'(0));
    chk_ge("timeout_duration", cyc - last_load, TB_TIMEOUT);
    loads_at_err = n_loads;
    repeat (40) @(negedge clk);
    chk("no_loads_after_error", 64'(n_loads), 64'(loads_at_err));
    chk("error_holds", 64'(seq_error), 64'(1));
    stuck_release = 1'b1;
    repeat (3) @(negedge clk);
    stuck_release = 1'b0;
    stuck_idx = -1;
  endtask
`endif

  initial begin
    rst_n = 1'b1;
    start = 1'b0;
    #3 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", all_outputs(), 64'(0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_outputs", all_outputs(), 64'(0));
    for (int r = 0; r < 4; r++) run_table(r != 0);
    reset_mid_run();
    run_table(1'b1);
`ifdef TIMEOUT_EN
    timeout_run();
    run_table(1'b0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
